sop_share_error_scanner: RTL and testbench

- Runtime-programmable controller and evaluator for a shared-logic single-level SOP approximation of the abs_diff benchmark.
- Holds the product literal masks and the product-to-output activation matrix as configuration.
- Sequences an exhaustive sweep of all 2^NUM_IN input vectors, comparing the approximate SOP output against the exact |a-b| and accumulating error statistics.
- Sits beside the synthesized approximate circuits; used for on-chip error validation of candidate configurations against threshold ET.

---
 rtl/sop_scan_pkg.sv | 31 +++
 rtl/sop_share_error_scanner_if.sv | 37 +++
 rtl/sop_share_eval.sv | 33 +++
 rtl/sop_share_error_scanner.sv | 153 +++++++++++++++
 tb/tb_sop_share_error_scanner.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sop_scan_pkg.sv
// rtl/sop_scan_pkg.sv - shared types, geometry and helpers for the SOP error scanner
package sop_scan_pkg;

  localparam int NUM_IN_DEF   = 4;
  localparam int NUM_OUT_DEF  = 2;
  localparam int NUM_PROD_DEF = 6;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SCAN  = ST_SCAN,
    DRAIN = ST_DRAIN,
    DONE  = ST_DONE
  } scan_state_e;

  typedef struct packed {
    logic [NUM_IN_DEF-1:0]  lit_use;
    logic [NUM_IN_DEF-1:0]  lit_pol;
    logic [NUM_OUT_DEF-1:0] act;
  } prod_cfg_t;

  // fail count must reach 2^num_in without wrapping
  function automatic int fail_cnt_w(input int num_in);
    return num_in + 1;
  endfunction

endpackage

// File: rtl/sop_share_error_scanner_if.sv
// rtl/sop_share_error_scanner_if.sv - config, control and result bundle of the SOP error scanner
interface sop_share_error_scanner_if
  import sop_scan_pkg::*;
#(
  parameter int NUM_IN   = NUM_IN_DEF,
  parameter int NUM_OUT  = NUM_OUT_DEF,
  parameter int NUM_PROD = NUM_PROD_DEF
) ();

  localparam int SEL_W = (NUM_PROD > 1) ? $clog2(NUM_PROD) : 1;

  logic                          cfg_valid;
  logic                          cfg_ready;
  logic [SEL_W-1:0]              cfg_sel;
  logic [NUM_IN-1:0]             cfg_lit_use;
  logic [NUM_IN-1:0]             cfg_lit_pol;
  logic [NUM_OUT-1:0]            cfg_act;
  logic                          start;
  logic                          busy;
  logic                          res_valid;
  logic                          res_ready;
  logic [NUM_OUT-1:0]            res_max_err;
  logic [fail_cnt_w(NUM_IN)-1:0] res_fail_cnt;
  logic                          res_pass;
  logic [NUM_IN-1:0]             res_first_fail;

  modport master (
    output cfg_valid, cfg_sel, cfg_lit_use, cfg_lit_pol, cfg_act, start, res_ready,
    input  cfg_ready, busy, res_valid, res_max_err, res_fail_cnt, res_pass, res_first_fail
  );

  modport slave (
    input  cfg_valid, cfg_sel, cfg_lit_use, cfg_lit_pol, cfg_act, start, res_ready,
    output cfg_ready, busy, res_valid, res_max_err, res_fail_cnt, res_pass, res_first_fail
  );

endinterface

// File: rtl/sop_share_eval.sv
// rtl/sop_share_eval.sv - combinational shared-product SOP evaluator (vec + config -> approx)
module sop_share_eval
  import sop_scan_pkg::*;
#(
  parameter int NUM_IN   = NUM_IN_DEF,
  parameter int NUM_OUT  = NUM_OUT_DEF,
  parameter int NUM_PROD = NUM_PROD_DEF
) (
  input  logic [NUM_IN-1:0]           vec,
  input  prod_cfg_t [NUM_PROD-1:0]    cfg,
  output logic [NUM_OUT-1:0]          approx
);

  logic [NUM_PROD-1:0] prod_hit;

  // an unused literal forces its bit true, so an empty product evaluates to 1
  always_comb begin
    prod_hit = '0;
    for (int p = 0; p < NUM_PROD; p++) begin
      prod_hit[p] = &(~cfg[p].lit_use | ~(vec ^ cfg[p].lit_pol));
    end
  end

  always_comb begin
    approx = '0;
    for (int p = 0; p < NUM_PROD; p++) begin
      for (int j = 0; j < NUM_OUT; j++) begin
        approx[j] = approx[j] | (prod_hit[p] & cfg[p].act[j]);
      end
    end
  end

endmodule

// File: rtl/sop_share_error_scanner.sv
// rtl/sop_share_error_scanner.sv - exhaustive-sweep error scanner for the approximate |a-b| SOP
module sop_share_error_scanner
  import sop_scan_pkg::*;
#(
  parameter int NUM_IN        = NUM_IN_DEF,
  parameter int NUM_OUT       = NUM_OUT_DEF,
  parameter int NUM_PROD      = NUM_PROD_DEF,
  parameter int ET            = 3,
  parameter int ABORT_ON_FAIL = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  sop_share_error_scanner_if.slave   bus
);

  localparam int HALF  = NUM_IN / 2;
  localparam int CNT_W = fail_cnt_w(NUM_IN);
  localparam logic [CNT_W-1:0] LAST_VEC = CNT_W'((1 << NUM_IN) - 1);
  localparam logic [31:0]      ET_U     = 32'(ET);

  scan_state_e               state;
  prod_cfg_t [NUM_PROD-1:0]  cfg;
  logic [CNT_W-1:0]          cnt;
  logic                      drain_cnt;

  logic                      s1_valid;
  logic [NUM_IN-1:0]         s1_vec;
  logic [NUM_OUT-1:0]        s1_approx;
  logic [NUM_OUT-1:0]        s1_exact;

  logic [NUM_OUT-1:0]        max_err;
  logic [CNT_W-1:0]          fail_cnt;
  logic [NUM_IN-1:0]         first_fail;
  logic                      has_fail;
  logic                      pass_q;

  logic [NUM_IN-1:0]         vec;
  logic [HALF-1:0]           op_a;
  logic [HALF-1:0]           op_b;
  logic [NUM_OUT-1:0]        approx;
  logic [NUM_OUT-1:0]        exact;
  logic [NUM_OUT-1:0]        err;
  logic                      acc_en;
  logic                      fail;
  logic                      abort_now;
  logic                      cfg_fire;

  assign vec  = cnt[NUM_IN-1:0];
  assign op_a = vec[HALF-1:0];
  assign op_b = vec[NUM_IN-1:HALF];
  assign exact = (op_a > op_b) ? (op_a - op_b) : (op_b - op_a);

  sop_share_eval #(
    .NUM_IN   (NUM_IN),
    .NUM_OUT  (NUM_OUT),
    .NUM_PROD (NUM_PROD)
  ) u_eval (
    .vec    (vec),
    .cfg    (cfg),
    .approx (approx)
  );

  // stage 2 only accumulates while the sweep is live; a vector caught in stage 1 at abort is dropped
  assign err       = (s1_approx > s1_exact) ? (s1_approx - s1_exact) : (s1_exact - s1_approx);
  assign acc_en    = s1_valid && (state == SCAN || state == DRAIN);
  assign fail      = acc_en && (32'(err) > ET_U);
  assign abort_now = (ABORT_ON_FAIL != 0) && fail;
  assign cfg_fire  = bus.cfg_valid && bus.cfg_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_vec    <= '0;
      s1_approx <= '0;
      s1_exact  <= '0;
    end else begin
      s1_valid  <= (state == SCAN);
      s1_vec    <= vec;
      s1_approx <= approx;
      s1_exact  <= exact;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cfg        <= '0;
      cnt        <= '0;
      drain_cnt  <= 1'b0;
      max_err    <= '0;
      fail_cnt   <= '0;
      first_fail <= '0;
      has_fail   <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_fire && (32'(bus.cfg_sel) < 32'(NUM_PROD))) begin
            cfg[bus.cfg_sel] <= '{lit_use: bus.cfg_lit_use, lit_pol: bus.cfg_lit_pol, act: bus.cfg_act};
          end
          if (bus.start) begin
            state      <= SCAN;
            cnt        <= '0;
            drain_cnt  <= 1'b0;
            max_err    <= '0;
            fail_cnt   <= '0;
            first_fail <= '0;
            has_fail   <= 1'b0;
            pass_q     <= 1'b0;
          end
        end
        SCAN: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST_VEC) state <= DRAIN;
        end
        DRAIN: begin
          drain_cnt <= 1'b1;
          if (drain_cnt) state <= DONE;
        end
        DONE: begin
          if (bus.res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (acc_en) begin
        if (err > max_err) max_err <= err;
        if (fail) begin
          fail_cnt <= fail_cnt + 1'b1;
          if (!has_fail) begin
            has_fail   <= 1'b1;
            first_fail <= s1_vec;
          end
        end
      end

      if (abort_now) state <= DONE;
      // fail_cnt is final on the DRAIN exit edge since stage 1 is already empty there
      if ((state == DRAIN && drain_cnt) || abort_now) begin
        pass_q <= !abort_now && (fail_cnt == '0);
      end
    end
  end

  assign bus.cfg_ready      = (state == IDLE);
  assign bus.busy           = (state == SCAN) || (state == DRAIN);
  assign bus.res_valid      = (state == DONE);
  assign bus.res_max_err    = max_err;
  assign bus.res_fail_cnt   = fail_cnt;
  assign bus.res_pass       = pass_q;
  assign bus.res_first_fail = first_fail;

endmodule

// File: tb/tb_sop_share_error_scanner.sv
// tb/tb_sop_share_error_scanner.sv - randomized bench for three scanner variants against a sweep model
module tb_sop_share_error_scanner;
  import sop_scan_pkg::*;

  localparam int NI = 4;
  localparam int NO = 2;
  localparam int NP = 6;
  localparam int NV = 1 << NI;
  localparam int ND = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       cfg_valid;
  logic [2:0] cfg_sel;
  logic [3:0] cfg_lit_use;
  logic [3:0] cfg_lit_pol;
  logic [1:0] cfg_act;
  logic       start;
  logic       res_ready;

  sop_share_error_scanner_if #(.NUM_IN(NI), .NUM_OUT(NO), .NUM_PROD(NP)) if_a ();
  sop_share_error_scanner_if #(.NUM_IN(NI), .NUM_OUT(NO), .NUM_PROD(NP)) if_b ();
  sop_share_error_scanner_if #(.NUM_IN(NI), .NUM_OUT(NO), .NUM_PROD(NP)) if_c ();

  assign if_a.cfg_valid = cfg_valid;   assign if_a.cfg_sel = cfg_sel;   assign if_a.cfg_lit_use = cfg_lit_use;
  assign if_a.cfg_lit_pol = cfg_lit_pol; assign if_a.cfg_act = cfg_act; assign if_a.start = start;
  assign if_a.res_ready = res_ready;
  assign if_b.cfg_valid = cfg_valid;   assign if_b.cfg_sel = cfg_sel;   assign if_b.cfg_lit_use = cfg_lit_use;
  assign if_b.cfg_lit_pol = cfg_lit_pol; assign if_b.cfg_act = cfg_act; assign if_b.start = start;
  assign if_b.res_ready = res_ready;
  assign if_c.cfg_valid = cfg_valid;   assign if_c.cfg_sel = cfg_sel;   assign if_c.cfg_lit_use = cfg_lit_use;
  assign if_c.cfg_lit_pol = cfg_lit_pol; assign if_c.cfg_act = cfg_act; assign if_c.start = start;
  assign if_c.res_ready = res_ready;

  sop_share_error_scanner #(.NUM_IN(NI), .NUM_OUT(NO), .NUM_PROD(NP), .ET(3), .ABORT_ON_FAIL(0))
    dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  sop_share_error_scanner #(.NUM_IN(NI), .NUM_OUT(NO), .NUM_PROD(NP), .ET(1), .ABORT_ON_FAIL(0))
    dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));
  sop_share_error_scanner #(.NUM_IN(NI), .NUM_OUT(NO), .NUM_PROD(NP), .ET(1), .ABORT_ON_FAIL(1))
    dut_c (.clk(clk), .rst(rst), .bus(if_c.slave));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // reference model state
  bit [3:0] m_use [NP];
  bit [3:0] m_pol [NP];
  bit [1:0] m_act [NP];
  int et_of [ND] = '{3, 1, 1};
  bit ab_of [ND] = '{0, 0, 1};
  int e_max [ND], e_fail [ND], e_ff [ND], e_lat [ND];

  logic [31:0] o_valid [ND], o_ready [ND], o_busy [ND], o_max [ND];
  logic [31:0] o_fail [ND], o_pass [ND], o_ff [ND];

  task automatic clear_model();
    for (int p = 0; p < NP; p++) begin
      m_use[p] = '0; m_pol[p] = '0; m_act[p] = '0;
    end
  endtask

  function automatic bit prod_true(input int p, input int v);
    for (int i = 0; i < NI; i++) begin
      if (m_use[p][i] && (((v >> i) & 1) != int'(m_pol[p][i]))) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic compute_model();
    for (int d = 0; d < ND; d++) begin
      int mx, fc, ff, lat;
      bit stop;
      mx = 0; fc = 0; ff = 0; lat = NV + 2; stop = 1'b0;
      for (int v = 0; v < NV && !stop; v++) begin
        int a, b, ap, ex, er;
        a = v % (1 << (NI / 2));
        b = v / (1 << (NI / 2));
        ap = 0;
        for (int j = 0; j < NO; j++) begin
          bit o;
          o = 1'b0;
          for (int p = 0; p < NP; p++) if (m_act[p][j] && prod_true(p, v)) o = 1'b1;
          if (o) ap += (1 << j);
        end
        ex = (a > b) ? a - b : b - a;
        er = (ap > ex) ? ap - ex : ex - ap;
        if (er > mx) mx = er;
        if (er > et_of[d]) begin
          if (fc == 0) ff = v;
          fc++;
          if (ab_of[d]) begin
            stop = 1'b1;
            lat  = v + 2;
          end
        end
      end
      e_max[d] = mx; e_fail[d] = fc; e_ff[d] = ff; e_lat[d] = lat;
    end
  endtask

  task automatic grab();
    o_valid[0] = 32'(if_a.res_valid); o_ready[0] = 32'(if_a.cfg_ready); o_busy[0] = 32'(if_a.busy);
    o_max[0] = 32'(if_a.res_max_err); o_fail[0] = 32'(if_a.res_fail_cnt);
    o_pass[0] = 32'(if_a.res_pass); o_ff[0] = 32'(if_a.res_first_fail);
    o_valid[1] = 32'(if_b.res_valid); o_ready[1] = 32'(if_b.cfg_ready); o_busy[1] = 32'(if_b.busy);
    o_max[1] = 32'(if_b.res_max_err); o_fail[1] = 32'(if_b.res_fail_cnt);
    o_pass[1] = 32'(if_b.res_pass); o_ff[1] = 32'(if_b.res_first_fail);
    o_valid[2] = 32'(if_c.res_valid); o_ready[2] = 32'(if_c.cfg_ready); o_busy[2] = 32'(if_c.busy);
    o_max[2] = 32'(if_c.res_max_err); o_fail[2] = 32'(if_c.res_fail_cnt);
    o_pass[2] = 32'(if_c.res_pass); o_ff[2] = 32'(if_c.res_first_fail);
  endtask

  task automatic check_results(input string tag);
    grab();
    for (int d = 0; d < ND; d++) begin
      check_eq($sformatf("%s d%0d res_valid", tag, d), o_valid[d], 1);
      check_eq($sformatf("%s d%0d max_err", tag, d), o_max[d], e_max[d]);
      check_eq($sformatf("%s d%0d fail_cnt", tag, d), o_fail[d], e_fail[d]);
      check_eq($sformatf("%s d%0d first_fail", tag, d), o_ff[d], e_ff[d]);
      check_eq($sformatf("%s d%0d pass", tag, d), o_pass[d], (e_fail[d] == 0) ? 1 : 0);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    grab();
    for (int d = 0; d < ND; d++) begin
      check_eq($sformatf("%s d%0d cfg_ready", tag, d), o_ready[d], 1);
      check_eq($sformatf("%s d%0d busy", tag, d), o_busy[d], 0);
      check_eq($sformatf("%s d%0d res_valid", tag, d), o_valid[d], 0);
      check_eq($sformatf("%s d%0d res_all", tag, d), {o_max[d], o_fail[d]} | {o_pass[d], o_ff[d]}, 0);
    end
  endtask

  task automatic cfg_write(input logic [2:0] s, input logic [3:0] u, input logic [3:0] pl, input logic [1:0] ac);
    @(negedge clk);
    cfg_valid = 1'b1; cfg_sel = s; cfg_lit_use = u; cfg_lit_pol = pl; cfg_act = ac;
    @(posedge clk);
    if (int'(s) < NP) begin
      m_use[s] = u; m_pol[s] = pl; m_act[s] = ac;
    end
    #1 cfg_valid = 1'b0;
  endtask

  task automatic run_sweep(input string tag, input bit interfere, input bit cws,
                           input logic [2:0] s, input logic [3:0] u, input logic [3:0] pl,
                           input logic [1:0] ac);
    int lat [ND];
    for (int d = 0; d < ND; d++) lat[d] = -1;
    @(negedge clk);
    start = 1'b1;
    if (cws) begin
      cfg_valid = 1'b1; cfg_sel = s; cfg_lit_use = u; cfg_lit_pol = pl; cfg_act = ac;
    end
    @(posedge clk);
    if (cws && int'(s) < NP) begin
      m_use[s] = u; m_pol[s] = pl; m_act[s] = ac;
    end
    #1 start = 1'b0; cfg_valid = 1'b0;
    compute_model();
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1 grab();
      for (int d = 0; d < ND; d++) if (lat[d] < 0 && o_valid[d] == 1) lat[d] = n;
      if (interfere) begin
        if (n >= 4 && n <= 10) begin
          check_eq($sformatf("%s scan cfg_ready n%0d", tag, n), o_ready[0], 0);
          check_eq($sformatf("%s scan busy n%0d", tag, n), o_busy[0], 1);
        end
        if (n == 3) begin
          cfg_valid = 1'b1; cfg_sel = 3'd0; cfg_lit_use = 4'b0011; cfg_lit_pol = 4'b0001; cfg_act = 2'b01;
        end
        if (n == 5) start = 1'b1;
        if (n == 6) start = 1'b0;
        if (n == 11) cfg_valid = 1'b0;
      end
      if (n > 11 && lat[0] >= 0 && lat[1] >= 0 && lat[2] >= 0) break;
    end
    cfg_valid = 1'b0;
    start = 1'b0;
    for (int d = 0; d < ND; d++) check_eq($sformatf("%s d%0d latency", tag, d), 64'(lat[d]), 64'(e_lat[d]));
    check_results(tag);
    repeat (5) @(posedge clk);
    #1 check_results({tag, " hold"});
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    grab();
    for (int d = 0; d < ND; d++) begin
      check_eq($sformatf("%s d%0d valid after ack", tag, d), o_valid[d], 0);
      check_eq($sformatf("%s d%0d cfg_ready after ack", tag, d), o_ready[d], 1);
      check_eq($sformatf("%s d%0d fail_cnt persists", tag, d), o_fail[d], e_fail[d]);
    end
  endtask

  task automatic run_reset_test();
    int seen;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1 check_idle_zero("mid-scan reset");
    rst = 1'b0;
    clear_model();
    seen = 0;
    repeat (25) begin
      @(posedge clk);
      #1 grab();
      if (o_valid[0] == 1 || o_valid[1] == 1 || o_valid[2] == 1) seen = 1;
    end
    check_eq("post-reset res_valid seen", 64'(seen), 0);
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_sel = '0; cfg_lit_use = '0; cfg_lit_pol = '0; cfg_act = '0;
    start = 1'b0; res_ready = 1'b0;
    clear_model();
    repeat (3) @(posedge clk);
    #1 check_idle_zero("reset");
    rst = 1'b0;

    run_sweep("zero cfg", 1'b0, 1'b0, 3'd0, 4'd0, 4'd0, 2'd0);
    check_eq("zero cfg a max_err", o_max[0], 3);
    check_eq("zero cfg a pass", o_pass[0], 1);
    check_eq("zero cfg b fail_cnt", o_fail[1], 6);
    check_eq("zero cfg b first_fail", o_ff[1], 2);
    check_eq("zero cfg c fail_cnt", o_fail[2], 1);
    check_eq("zero cfg c first_fail", o_ff[2], 2);

    cfg_write(3'd0, 4'b0000, 4'b0000, 2'b11);
    run_sweep("const3 interfere", 1'b1, 1'b0, 3'd0, 4'd0, 4'd0, 2'd0);
    check_eq("const3 b fail_cnt", o_fail[1], 10);
    check_eq("const3 b max_err", o_max[1], 3);

    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 8; k++) begin
        cfg_write(3'($urandom_range(0, 7)), 4'($urandom & $urandom), 4'($urandom), 2'($urandom));
      end
      run_sweep($sformatf("rand%0d", r), 1'b0, (r % 2) == 1, 3'($urandom_range(0, 7)),
                4'($urandom & $urandom), 4'($urandom), 2'($urandom));
    end

    run_reset_test();
    run_sweep("after reset", 1'b0, 1'b0, 3'd0, 4'd0, 4'd0, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1);
  end

endmodule
